// File: rtl/answer_pattern_gen_pkg.sv
// Shared types and constants for the mole-game answer pattern source.
// Holds the FSM state type and the LFSR / answer-word geometry.
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam int NIBBLES_PER_WORD = 8;
  localparam int NIBBLE_W = 4;
  localparam int WORD_W = NIBBLES_PER_WORD * NIBBLE_W;
  localparam int IDX_W = $clog2(NIBBLES_PER_WORD);

endpackage

// File: rtl/answer_pattern_gen_if.sv
// Request / answer-word bundle between the game core and the pattern source.
// master: game core side, slave: pattern generator side.
interface answer_pattern_gen_if;

  logic        game_start;
  logic        change_answer;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [31:0] data_out;
  logic        write_enable;
  logic        busy;
  logic [7:0]  pattern_count;

  modport master (
    output game_start,
    output change_answer,
    output seed_load,
    output seed_in,
    input  data_out,
    input  write_enable,
    input  busy,
    input  pattern_count
  );

  modport slave (
    input  game_start,
    input  change_answer,
    input  seed_load,
    input  seed_in,
    output data_out,
    output write_enable,
    output busy,
    output pattern_count
  );

endinterface

// File: rtl/answer_pattern_gen_lfsr.sv
// 16-bit Galois LFSR with seed load; a zero seed is replaced by
// SEED_RST so the register can never lock up at zero.
module lfsr16_galois
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_step;

  assign q_step = (q >> 1) ^ (q[0] ? LFSR_POLY : 16'h0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED_RST;
    end else if (load) begin
      q <= (seed == 16'h0000) ? SEED_RST : seed;
    end else if (en) begin
      q <= q_step;
    end
  end

endmodule

// File: rtl/answer_pattern_gen.sv
// Answer pattern source: assembles 8 random hole positions per request.
// Define PATTERN_NO_REPEAT_EN to forbid equal adjacent nibbles in a word.
module answer_pattern_gen
  import mole_pkg::*;
#(
  parameter int          NUM_HOLES = 9,
  parameter logic [15:0] SEED_RST  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  answer_pattern_gen_if.slave  bus
);

  localparam logic [NIBBLE_W:0] HOLES = (NIBBLE_W + 1)'(NUM_HOLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES_PER_WORD - 1);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [WORD_W-1:0]   sr;
  logic [WORD_W-1:0]   sr_nxt;
  logic [WORD_W-1:0]   word_q;
  logic [7:0]          cnt_q;
  logic                pending;
  logic [15:0]         q;
  logic [NIBBLE_W-1:0] cand;
  logic                req;
  logic                accept;
  logic                last;

  assign req  = bus.game_start | bus.change_answer;
  assign cand = q[NIBBLE_W-1:0];

  lfsr16_galois #(
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (bus.seed_load && (state == IDLE)),
    .en    (state == FILL),
    .seed  (bus.seed_in),
    .q     (q)
  );

  always_comb begin
    accept = ({1'b0, cand} < HOLES);
`ifdef PATTERN_NO_REPEAT_EN
    // sr's top nibble is the most recently accepted one
    if ((idx != '0) && (cand == sr[WORD_W-1 -: NIBBLE_W])) begin
      accept = 1'b0;
    end
`endif
    last   = accept && (idx == LAST_IDX);
    sr_nxt = {cand, sr[WORD_W-1:NIBBLE_W]};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = FILL;
      FILL:    if (last) state_nxt = DONE;
      DONE:    state_nxt = (pending || req) ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      sr      <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (req) begin
            idx <= '0;
            sr  <= '0;
          end
        end
        FILL: begin
          if (req) pending <= 1'b1;
          if (accept) begin
            sr  <= sr_nxt;
            idx <= idx + 1'b1;
          end
          // publish the finished word as DONE begins
          if (last) begin
            word_q <= sr_nxt;
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          pending <= 1'b0;
          idx     <= '0;
          sr      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out      = word_q;
  assign bus.write_enable  = (state == DONE);
  assign bus.busy          = (state != IDLE);
  assign bus.pattern_count = cnt_q;

endmodule
